ddr3_wb_arbiter: RTL and testbench

Two-master, one-slave pipelined Wishbone arbiter that shares the single UberDDR3 `ddr3_top` Wishbone port between two requesters, e.g. the `ddr3_test` traffic generator (master 0) and a UART/debug bus master (master 1). It sits between the masters and the controller in the controller clock domain. It holds off all traffic until calibration completes, grants the bus round-robin per Wishbone cycle, and caps outstanding requests. It routes each ack, with its data and aux, back to the owning master.

---
 rtl/ddr3_wb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ddr3_wb_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_wb_arbiter.sv
// Two-master, one-slave pipelined Wishbone arbiter for the UberDDR3 controller port.
// Round-robin per Wishbone cycle, gated by calibration, with an outstanding-request cap.
module ddr3_wb_arbiter #(
    parameter int unsigned WB_ADDR_BITS    = 25,
    parameter int unsigned WB_DATA_BITS    = 512,
    parameter int unsigned WB_SEL_BITS     = 64,
    parameter int unsigned AUX_WIDTH       = 16,
    parameter int unsigned MAX_OUTSTANDING = 15
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_calib_complete,
    // master 0
    input  logic                    i_m0_cyc,
    input  logic                    i_m0_stb,
    input  logic                    i_m0_we,
    input  logic [WB_ADDR_BITS-1:0] i_m0_addr,
    input  logic [WB_DATA_BITS-1:0] i_m0_data,
    input  logic [WB_SEL_BITS-1:0]  i_m0_sel,
    input  logic [AUX_WIDTH-1:0]    i_m0_aux,
    output logic                    o_m0_stall,
    output logic                    o_m0_ack,
    output logic [WB_DATA_BITS-1:0] o_m0_data,
    output logic [AUX_WIDTH-1:0]    o_m0_aux,
    // master 1
    input  logic                    i_m1_cyc,
    input  logic                    i_m1_stb,
    input  logic                    i_m1_we,
    input  logic [WB_ADDR_BITS-1:0] i_m1_addr,
    input  logic [WB_DATA_BITS-1:0] i_m1_data,
    input  logic [WB_SEL_BITS-1:0]  i_m1_sel,
    input  logic [AUX_WIDTH-1:0]    i_m1_aux,
    output logic                    o_m1_stall,
    output logic                    o_m1_ack,
    output logic [WB_DATA_BITS-1:0] o_m1_data,
    output logic [AUX_WIDTH-1:0]    o_m1_aux,
    // controller side
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    output logic                    o_wb_we,
    output logic [WB_ADDR_BITS-1:0] o_wb_addr,
    output logic [WB_DATA_BITS-1:0] o_wb_data,
    output logic [WB_SEL_BITS-1:0]  o_wb_sel,
    output logic [AUX_WIDTH-1:0]    o_aux,
    input  logic                    i_wb_stall,
    input  logic                    i_wb_ack,
    input  logic [WB_DATA_BITS-1:0] i_wb_data,
    input  logic [AUX_WIDTH-1:0]    i_aux,
    // status
    output logic [1:0]              o_grant,
    output logic                    o_spurious_ack
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        state, state_next;
    logic          last, last_next;
    logic [CW-1:0] cnt, cnt_next;

    logic g0, g1;
    logic own_cyc, own_stb;
    logic full, cnt_nz, accept, ack_ok;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= '0;
        end else begin
            state <= state_next;
            last  <= last_next;
            cnt   <= cnt_next;
        end
    end

    assign g0      = (state == GNT0);
    assign g1      = (state == GNT1);
    assign o_grant = {g1, g0};

    assign full   = (cnt == CNT_MAX);
    assign cnt_nz = (cnt != '0);

    assign own_cyc = (g0 & i_m0_cyc) | (g1 & i_m1_cyc);
    assign own_stb = (g0 & i_m0_stb) | (g1 & i_m1_stb);

    // stb is additionally qualified by cyc so a strobe during the abort cycle is never issued
    assign o_wb_cyc  = own_cyc;
    assign o_wb_stb  = own_cyc & own_stb & ~full;
    assign o_wb_we   = g1 ? i_m1_we   : i_m0_we;
    assign o_wb_addr = g1 ? i_m1_addr : i_m0_addr;
    assign o_wb_data = g1 ? i_m1_data : i_m0_data;
    assign o_wb_sel  = g1 ? i_m1_sel  : i_m0_sel;
    assign o_aux     = g1 ? i_m1_aux  : i_m0_aux;

    assign accept = o_wb_stb & ~i_wb_stall;
    assign ack_ok = i_wb_ack & cnt_nz & (g0 | g1);

    assign o_m0_stall = ~g0 | i_wb_stall | full;
    assign o_m1_stall = ~g1 | i_wb_stall | full;
    assign o_m0_ack   = i_wb_ack & g0 & cnt_nz;
    assign o_m1_ack   = i_wb_ack & g1 & cnt_nz;
    assign o_m0_data  = i_wb_data;
    assign o_m1_data  = i_wb_data;
    assign o_m0_aux   = i_aux;
    assign o_m1_aux   = i_aux;

    assign o_spurious_ack = i_wb_ack & ~cnt_nz;

    always_comb begin
        state_next = state;
        last_next  = last;
        cnt_next   = cnt;

        if (accept && !ack_ok) begin
            cnt_next = cnt + CW'(1);
        end else if (!accept && ack_ok) begin
            cnt_next = cnt - CW'(1);
        end

        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (i_calib_complete) begin
                    if (i_m0_cyc && i_m1_cyc) begin
                        state_next = last ? GNT0 : GNT1;
                    end else if (i_m0_cyc) begin
                        state_next = GNT0;
                    end else if (i_m1_cyc) begin
                        state_next = GNT1;
                    end
                end
            end
            GNT0: begin
                if (!i_m0_cyc) begin
                    state_next = IDLE;
                    last_next  = 1'b0;
                    cnt_next   = '0;
                end
            end
            GNT1: begin
                if (!i_m1_cyc) begin
                    state_next = IDLE;
                    last_next  = 1'b1;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ddr3_wb_arbiter.sv
// Directed bench for ddr3_wb_arbiter: calibration gate, tie/round-robin, outstanding cap,
// random counter consistency, abort with spurious acks, and reset mid-transfer.
module tb_ddr3_wb_arbiter;

    localparam int unsigned AW = 25;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int unsigned XW = 16;
    localparam int unsigned MO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          calib = 1'b0;
    logic          m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [DW-1:0] m0_wdata = '0;
    logic [SW-1:0] m0_sel = '0;
    logic [XW-1:0] m0_aux = '0;
    logic          m0_stall, m0_ack;
    logic [DW-1:0] m0_rdata;
    logic [XW-1:0] m0_raux;
    logic          m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic [SW-1:0] m1_sel = '0;
    logic [XW-1:0] m1_aux = '0;
    logic          m1_stall, m1_ack;
    logic [DW-1:0] m1_rdata;
    logic [XW-1:0] m1_raux;
    logic          wb_cyc, wb_stb, wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_wdata;
    logic [SW-1:0] wb_sel;
    logic [XW-1:0] wb_aux;
    logic          wb_stall = 1'b0, wb_ack = 1'b0;
    logic [DW-1:0] wb_rdata = '0;
    logic [XW-1:0] wb_raux = '0;
    logic [1:0]    grant;
    logic          spurious;

    int unsigned checks = 0;
    int unsigned failures = 0;

    always #5 clk = ~clk;

    ddr3_wb_arbiter #(
        .WB_ADDR_BITS(AW), .WB_DATA_BITS(DW), .WB_SEL_BITS(SW),
        .AUX_WIDTH(XW), .MAX_OUTSTANDING(MO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_calib_complete(calib),
        .i_m0_cyc(m0_cyc), .i_m0_stb(m0_stb), .i_m0_we(m0_we), .i_m0_addr(m0_addr),
        .i_m0_data(m0_wdata), .i_m0_sel(m0_sel), .i_m0_aux(m0_aux),
        .o_m0_stall(m0_stall), .o_m0_ack(m0_ack), .o_m0_data(m0_rdata), .o_m0_aux(m0_raux),
        .i_m1_cyc(m1_cyc), .i_m1_stb(m1_stb), .i_m1_we(m1_we), .i_m1_addr(m1_addr),
        .i_m1_data(m1_wdata), .i_m1_sel(m1_sel), .i_m1_aux(m1_aux),
        .o_m1_stall(m1_stall), .o_m1_ack(m1_ack), .o_m1_data(m1_rdata), .o_m1_aux(m1_raux),
        .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .o_wb_addr(wb_addr),
        .o_wb_data(wb_wdata), .o_wb_sel(wb_sel), .o_aux(wb_aux),
        .i_wb_stall(wb_stall), .i_wb_ack(wb_ack), .i_wb_data(wb_rdata), .i_aux(wb_raux),
        .o_grant(grant), .o_spurious_ack(spurious)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int unsigned mcnt;
    logic        r_stb, r_stall, r_ack, e_stb, e_acc, e_ack;

    initial begin
        // reset values
        step();
        step();
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_cyc_stb", {wb_cyc, wb_stb}, 2'b00);
        chk("rst_stall", {m0_stall, m1_stall}, 2'b11);
        chk("rst_ack", {m0_ack, m1_ack, spurious}, 3'b000);
        rst = 1'b0;

        // calibration gate
        m0_cyc = 1'b1;
        m0_stb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            #1;
            chk("calgate", {wb_cyc, m0_stall}, 2'b01);
        end
        calib = 1'b1;
        #1;
        chk("cal_k_grant", grant, 2'b00);
        step();
        #1;
        chk("cal_k1_grant", grant, 2'b01);
        chk("cal_k1_cyc_stb", {wb_cyc, wb_stb}, 2'b11);
        m0_cyc = 1'b0;
        m0_stb = 1'b0;
        step();

        // tie: master 0 first after reset
        do_reset();
        m0_cyc = 1'b1;
        m1_cyc = 1'b1;
        #1;
        chk("tie_pre_grant", grant, 2'b00);
        step();
        #1;
        chk("tie_grant0", grant, 2'b01);
        chk("tie_m1_stall", m1_stall, 1'b1);
        for (int i = 0; i < 4; i++) begin
            m0_stb = 1'b1;
            m0_we = 1'b1;
            m0_addr = AW'(32'h100 + i);
            m0_wdata = 32'hD000_0000 + i;
            m0_sel = 4'hF;
            #1;
            chk("w_stb_we", {wb_stb, wb_we}, 2'b11);
            chk("w_addr", wb_addr, 64'h100 + i);
            chk("w_data", wb_wdata, 64'hD000_0000 + i);
            step();
        end
        m0_stb = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_ack = 1'b1;
            wb_raux = XW'(16'h50 + i);
            #1;
            chk("w_ack_route", {m0_ack, m1_ack, spurious}, 3'b100);
            step();
        end
        wb_ack = 1'b0;
        m0_cyc = 1'b0;
        #1;
        chk("w_drop_cyc", wb_cyc, 1'b0);
        step();
        #1;
        chk("rr_gap_grant", grant, 2'b00);
        step();
        #1;
        chk("rr_grant1", grant, 2'b10);
        chk("rr_m0_stall", m0_stall, 1'b1);
        for (int i = 0; i < 3; i++) begin
            m1_stb = 1'b1;
            m1_we = 1'b0;
            m1_addr = AW'(32'h200 + i);
            m1_aux = XW'(16'hA0 + i);
            #1;
            chk("r_req", {wb_stb, wb_we, wb_aux}, {2'b10, 16'hA0 + 16'(i)});
            step();
        end
        m1_stb = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_ack = 1'b1;
            wb_raux = XW'(16'hA0 + i);
            wb_rdata = 32'hCAFE_0000 + i;
            #1;
            chk("r_ack_route", {m0_ack, m1_ack}, 2'b01);
            chk("r_aux", m1_raux, 64'hA0 + i);
            chk("r_data", m1_rdata, 64'hCAFE_0000 + i);
            step();
        end
        wb_ack = 1'b0;
        m1_cyc = 1'b0;
        step();

        // outstanding cap with acks withheld
        do_reset();
        m0_cyc = 1'b1;
        step();
        m0_stb = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("cap_stream", {wb_stb, m0_stall}, (i < 4) ? 2'b10 : 2'b01);
            step();
        end
        wb_ack = 1'b1;
        #1;
        chk("cap_full_ack", {wb_stb, m0_ack}, 2'b01);
        step();
        #1;
        chk("cap_acc_and_ack", {wb_stb, m0_ack}, 2'b11);
        step();
        wb_ack = 1'b0;
        #1;
        chk("cap_one_more", {wb_stb, m0_stall}, 2'b10);
        step();
        #1;
        chk("cap_refull", {wb_stb, m0_stall}, 2'b01);
        m0_cyc = 1'b0;
        m0_stb = 1'b0;
        step();

        // random counter consistency against a reference count
        m0_cyc = 1'b1;
        step();
        mcnt = 0;
        for (int i = 0; i < 1000; i++) begin
            r_stb = 1'($urandom_range(1));
            r_stall = 1'($urandom_range(1));
            r_ack = ($urandom_range(2) == 0);
            m0_stb = r_stb;
            wb_stall = r_stall;
            wb_ack = r_ack;
            e_stb = r_stb & (mcnt != MO);
            e_acc = e_stb & ~r_stall;
            e_ack = r_ack & (mcnt != 0);
            #1;
            chk("rand", {wb_stb, m0_stall, m0_ack, spurious},
                {e_stb, r_stall | (mcnt == MO), e_ack, r_ack & (mcnt == 0)});
            if (e_acc && !e_ack) mcnt++;
            else if (!e_acc && e_ack) mcnt--;
            step();
        end
        m0_cyc = 1'b0;
        m0_stb = 1'b0;
        wb_stall = 1'b0;
        wb_ack = 1'b0;
        step();

        // abort with two pending, then stray acks
        m1_cyc = 1'b1;
        step();
        #1;
        chk("ab_grant1", grant, 2'b10);
        m1_stb = 1'b1;
        #1;
        chk("ab_stb", wb_stb, 1'b1);
        step();
        step();
        m1_stb = 1'b0;
        m1_cyc = 1'b0;
        #1;
        chk("ab_cyc_fall", wb_cyc, 1'b0);
        step();
        for (int i = 0; i < 2; i++) begin
            wb_ack = 1'b1;
            #1;
            chk("ab_spurious", {spurious, m1_ack, m0_ack}, 3'b100);
            step();
        end
        wb_ack = 1'b0;
        #1;
        chk("ab_spur_clear", spurious, 1'b0);

        // reset mid-transfer with three pending
        m0_cyc = 1'b1;
        step();
        m0_stb = 1'b1;
        repeat (3) step();
        m0_stb = 1'b0;
        m1_cyc = 1'b1;
        #1;
        chk("mr_pre_grant", {grant, m0_stall}, 3'b010);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m0_cyc = 1'b0;
        #1;
        chk("mr_rst_grant", grant, 2'b00);
        chk("mr_rst_outs", {wb_cyc, wb_stb, m0_stall, m1_stall}, 4'b0011);
        step();
        #1;
        chk("mr_grant1", grant, 2'b10);
        m1_stb = 1'b1;
        #1;
        chk("mr_cnt_clear", {wb_stb, m1_stall}, 2'b10);
        step();
        m1_stb = 1'b0;
        m1_cyc = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
